dense_layer_pmac: RTL

//  Parametrised fully-connected classifier stage: consumes the flattened pooled-feature stream and

---
 rtl/dense_layer_pmac.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dense_layer_pmac.sv
// Fully-connected classifier stage: LANES parallel MACs walk classes in groups, then add biases and stream saturated scores.
// Optional ARGMAX_EN adds a running argmax (pred_class / pred_valid) over the streamed scores.
module dense_layer_pmac #(
  parameter int INPUT_SIZE   = 676,
  parameter int OUTPUT_SIZE  = 10,
  parameter int LANES        = 2,
  parameter int DATA_WIDTH   = 20,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int OUT_WIDTH    = 24,
  localparam int GROUPS = OUTPUT_SIZE / LANES,
  localparam int WAW    = (INPUT_SIZE * GROUPS > 1) ? $clog2(INPUT_SIZE * GROUPS) : 1,
  localparam int BAW    = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int IW     = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic signed [DATA_WIDTH-1:0]      feature_in,
  input  logic                              feature_valid,
  output logic                              feature_ready,
  output logic                              weight_en,
  output logic [WAW-1:0]                    weight_addr,
  input  logic [LANES*WEIGHT_WIDTH-1:0]     weight_data,
  output logic                              bias_en,
  output logic [BAW-1:0]                    bias_addr,
  input  logic [LANES*BIAS_WIDTH-1:0]       bias_data,
  output logic signed [OUT_WIDTH-1:0]       score_out,
  output logic [IW-1:0]                     score_index,
  output logic                              score_valid,
  input  logic                              score_ready,
  output logic                              score_last,
  output logic                              busy,
  output logic                              done
`ifdef ARGMAX_EN
  ,
  output logic [IW-1:0]                     pred_class,
  output logic                              pred_valid
`endif
);

  if (OUTPUT_SIZE % LANES != 0) begin : g_size_check
    $fatal(1, "dense_layer_pmac: OUTPUT_SIZE must be a multiple of LANES");
  end

  localparam int FW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int BCW = $clog2(GROUPS + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, OUT} state_t;

  state_t                       state;
  logic [FW-1:0]                f;
  logic [BAW-1:0]               g;
  logic [BCW-1:0]               b;
  logic [IW-1:0]                k;
  logic signed [DATA_WIDTH-1:0] feature;
  logic signed [ACC_WIDTH-1:0]  acc      [OUTPUT_SIZE];
  logic signed [ACC_WIDTH-1:0]  prod     [LANES];
  logic signed [ACC_WIDTH-1:0]  bias_ext [LANES];
  logic signed [ACC_WIDTH-1:0]  acc_sel;

  function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (a < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
    else                  sat = a[OUT_WIDTH-1:0];
  endfunction

  // Products wrap in ACC_WIDTH, which equals the full product sign-extended then wrapped.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l]     = ACC_WIDTH'(feature) *
                    ACC_WIDTH'($signed(weight_data[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      bias_ext[l] = ACC_WIDTH'($signed(bias_data[l*BIAS_WIDTH +: BIAS_WIDTH]));
    end
  end

  always_comb begin
    acc_sel = acc[0];
    for (int c = 0; c < OUTPUT_SIZE; c++)
      if (c == int'(k)) acc_sel = acc[c];
  end

  // ROM strobes lead the data by one cycle, so they are issued from the current state.
  always_comb begin
    weight_en   = 1'b0;
    weight_addr = '0;
    bias_en     = 1'b0;
    bias_addr   = '0;
    case (state)
      LOAD: if (feature_valid) begin
        weight_en   = 1'b1;
        weight_addr = WAW'(int'(f) * GROUPS);
      end
      MAC: if (int'(g) < GROUPS - 1) begin
        weight_en   = 1'b1;
        weight_addr = WAW'(int'(f) * GROUPS + int'(g) + 1);
      end
      BIAS: if (int'(b) < GROUPS) begin
        bias_en   = 1'b1;
        bias_addr = BAW'(b);
      end
      default: ;
    endcase
  end

  assign feature_ready = (state == LOAD);
  assign score_valid   = (state == OUT);
  assign score_last    = (state == OUT) && (int'(k) == OUTPUT_SIZE - 1);
  assign score_index   = k;
  assign score_out     = sat(acc_sel);
  assign busy          = (state != IDLE);

`ifdef ARGMAX_EN
  logic signed [OUT_WIDTH-1:0] best;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      f       <= '0;
      g       <= '0;
      b       <= '0;
      k       <= '0;
      feature <= '0;
      done    <= 1'b0;
      for (int c = 0; c < OUTPUT_SIZE; c++) acc[c] <= '0;
`ifdef ARGMAX_EN
      best       <= '0;
      pred_class <= '0;
      pred_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ARGMAX_EN
      pred_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          for (int c = 0; c < OUTPUT_SIZE; c++) acc[c] <= '0;
          f     <= '0;
          state <= LOAD;
`ifdef ARGMAX_EN
          pred_class <= '0;
`endif
        end
        LOAD: if (feature_valid) begin
          feature <= feature_in;
          g       <= '0;
          state   <= MAC;
        end
        MAC: begin
          for (int c = 0; c < OUTPUT_SIZE; c++)
            if (c / LANES == int'(g)) acc[c] <= acc[c] + prod[c % LANES];
          if (int'(g) == GROUPS - 1) begin
            if (int'(f) == INPUT_SIZE - 1) begin
              b     <= '0;
              state <= BIAS;
            end else begin
              f     <= f + FW'(1);
              state <= LOAD;
            end
          end else begin
            g <= g + BAW'(1);
          end
        end
        BIAS: begin
          // Bias data for address b-1 arrives while address b is being issued.
          for (int c = 0; c < OUTPUT_SIZE; c++)
            if (b != '0 && c / LANES == int'(b) - 1) acc[c] <= acc[c] + bias_ext[c % LANES];
          if (int'(b) == GROUPS) begin
            k     <= '0;
            state <= OUT;
          end else begin
            b <= b + BCW'(1);
          end
        end
        OUT: if (score_ready) begin
`ifdef ARGMAX_EN
          if (k == '0 || score_out > best) begin
            best       <= score_out;
            pred_class <= k;
          end
`endif
          if (int'(k) == OUTPUT_SIZE - 1) begin
            done  <= 1'b1;
            state <= IDLE;
`ifdef ARGMAX_EN
            pred_valid <= 1'b1;
`endif
          end else begin
            k <= k + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
